// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler that serialises one requester word at a time into a shared
// "1011" Moore detector, counts detections, and reports the count with a valid/ready handshake.
module seq_det_scheduler #(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [3:0]     req_valid,
  input  logic [4*W-1:0] req_data,
  output logic [3:0]     req_ready,
  output logic           det_seq_in,
  output logic           det_reset,
  input  logic           det_out,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [1:0]     res_id,
  output logic [4:0]     res_count,
  output logic           res_hit,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;

  localparam logic [4:0] LAST_BIT = 5'(W - 1);
  localparam logic [4:0] HIT_MAX  = 5'd31;

  state_t       state_q, state_d;
  logic [W-1:0] word_q, word_d;
  logic [1:0]   id_q, id_d;
  logic [1:0]   rr_q, rr_d;
  logic [4:0]   hits_q, hits_d;
  logic [4:0]   cnt_q, cnt_d;

  logic [7:0]   valid_dbl;
  logic [3:0]   valid_rot;
  logic [1:0]   grant_off;
  logic [1:0]   grant_idx;
  logic         grant_any;

  // Rotate the request vector so that bit 0 is the requester at the round-robin pointer.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = valid_dbl[rr_q +: 4];
  assign grant_any = |req_valid;
  assign grant_idx = rr_q + grant_off;

  always_comb begin
    grant_off = 2'd3;
    if (valid_rot[0])      grant_off = 2'd0;
    else if (valid_rot[1]) grant_off = 2'd1;
    else if (valid_rot[2]) grant_off = 2'd2;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_BIT) state_d = DRAIN;
      DRAIN:   state_d = REPORT;
      REPORT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    word_d = word_q;
    id_d   = id_q;
    rr_d   = rr_q;
    hits_d = hits_q;
    cnt_d  = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          word_d = req_data[grant_idx*W +: W];
          id_d   = grant_idx;
          rr_d   = grant_idx + 2'd1;
          hits_d = '0;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        word_d = word_q << 1;
        cnt_d  = cnt_q + 5'd1;
        if (det_out && hits_q != HIT_MAX) hits_d = hits_q + 5'd1;
      end
      DRAIN: begin
        // Picks up the detection completed by the last shifted bit.
        if (det_out && hits_q != HIT_MAX) hits_d = hits_q + 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= '0;
      id_q   <= '0;
      rr_q   <= '0;
      hits_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      id_q   <= id_d;
      rr_q   <= rr_d;
      hits_q <= hits_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs are forced to their reset values while reset is asserted.
  always_comb begin
    req_ready  = '0;
    det_seq_in = 1'b0;
    det_reset  = reset || (state_q == IDLE);
    res_valid  = 1'b0;
    res_id     = '0;
    res_count  = '0;
    res_hit    = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE:   if (grant_any) req_ready = 4'b0001 << grant_idx;
        SHIFT:  det_seq_in = word_q[W-1];
        REPORT: begin
          res_valid = 1'b1;
          res_id    = id_q;
          res_count = hits_q;
          res_hit   = (hits_q != 5'd0);
        end
        default: ;
      endcase
    end
  end

endmodule
